tbu_ctrl: RTL and testbench

Traceback controller for the Viterbi decoder back end. It receives 8-bit ACS decision vectors and manages a 4-bank survivor-memory ring: it writes decision vectors into the banks and sequences the traceback reads, driving the traceback unit's enable/selection so each block runs a training pass then a decode pass. It captures the traceback unit's reversed decoded bits and streams them out in forward order over a valid/ready interface. It sits between the ACS array, the survivor RAM, the traceback unit and the decoded-bit sink.

---
 rtl/tbu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tbu_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tbu_ctrl.sv
// Traceback controller: 4-bank survivor-memory ring, train/decode traceback sequencing,
// and reversal of the traceback unit's output bits into a forward-order valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for two complete banks and an empty output buffer
// TRAIN  | reading the training bank, addresses DEPTH-1 down to 0
// DECODE | reading the decode bank, addresses DEPTH-1 down to 0
// FLUSH  | waiting for the last decoded bits, then releasing the decode bank
module tbu_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_dec,
    output logic          mem_wr_en,
    output logic [1:0]    mem_wr_bank,
    output logic [AW-1:0] mem_wr_addr,
    output logic [7:0]    mem_wr_data,
    output logic          mem_rd_en,
    output logic [1:0]    mem_rd_bank_0,
    output logic [1:0]    mem_rd_bank_1,
    output logic [AW-1:0] mem_rd_addr,
    output logic          tbu_enable,
    output logic          tbu_selection,
    input  logic          tbu_d_o,
    input  logic          tbu_wr_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, TRAIN, DECODE, FLUSH} state_t;

    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [AW:0]   CAP_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CAP_ONE  = (AW + 1)'(1);

    state_t          state;
    logic [1:0]      wr_bank, tb_base, filled_cnt, train_bank, dec_bank;
    logic [AW-1:0]   wr_addr, rd_addr, out_idx;
    logic [AW:0]     cap_cnt;
    logic            buf_full, rd_en, tbu_en_q, tbu_sel_q;
    logic [DEPTH-1:0] rev_buf;

    logic wr_fire, bank_done, bank_rel, out_fire, cap_fire;

    assign in_ready    = (filled_cnt != 2'd3);
    assign wr_fire     = in_valid & in_ready;
    assign bank_done   = wr_fire & (wr_addr == ADDR_MAX);
    assign bank_rel    = (state == FLUSH) & (cap_cnt == CAP_FULL);
    assign out_fire    = buf_full & out_ready;
    assign cap_fire    = tbu_wr_en & (cap_cnt < CAP_FULL) & ~buf_full;

    assign mem_wr_en     = wr_fire;
    assign mem_wr_bank   = wr_bank;
    assign mem_wr_addr   = wr_addr;
    assign mem_wr_data   = in_dec;
    assign mem_rd_en     = rd_en;
    assign mem_rd_bank_0 = train_bank;
    assign mem_rd_bank_1 = dec_bank;
    assign mem_rd_addr   = rd_addr;
    assign tbu_enable    = tbu_en_q;
    assign tbu_selection = tbu_sel_q;
    assign out_valid     = buf_full;
    assign out_bit       = rev_buf[out_idx];
    assign busy          = (state != IDLE) | buf_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr    <= '0;
            wr_bank    <= '0;
            filled_cnt <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_addr == ADDR_MAX) begin
                    wr_addr <= '0;
                    wr_bank <= wr_bank + 2'd1;
                end else begin
                    wr_addr <= wr_addr + ADDR_ONE;
                end
            end
            // simultaneous completion and release cancel out
            case ({bank_done, bank_rel})
                2'b10:   filled_cnt <= filled_cnt + 2'd1;
                2'b01:   filled_cnt <= filled_cnt - 2'd1;
                default: filled_cnt <= filled_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rd_addr    <= '0;
            rd_en      <= 1'b0;
            tb_base    <= '0;
            train_bank <= '0;
            dec_bank   <= '0;
            tbu_en_q   <= 1'b0;
            tbu_sel_q  <= 1'b0;
        end else begin
            // RAM has one cycle of latency, so the tbu controls trail the read strobe
            tbu_en_q  <= rd_en;
            tbu_sel_q <= rd_en & (state == DECODE);
            case (state)
                IDLE: begin
                    if (filled_cnt >= 2'd2 && !buf_full) begin
                        state      <= TRAIN;
                        train_bank <= tb_base + 2'd1;
                        dec_bank   <= tb_base;
                        rd_addr    <= ADDR_MAX;
                        rd_en      <= 1'b1;
                    end
                end
                TRAIN: begin
                    if (rd_addr == '0) begin
                        state   <= DECODE;
                        rd_addr <= ADDR_MAX;
                    end else begin
                        rd_addr <= rd_addr - ADDR_ONE;
                    end
                end
                DECODE: begin
                    if (rd_addr == '0) begin
                        state <= FLUSH;
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr - ADDR_ONE;
                    end
                end
                FLUSH: begin
                    if (bank_rel) begin
                        tb_base <= tb_base + 2'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_cnt  <= '0;
            rev_buf  <= '0;
            out_idx  <= '0;
            buf_full <= 1'b0;
        end else begin
            if (out_fire) begin
                if (out_idx == ADDR_MAX) begin
                    out_idx  <= '0;
                    buf_full <= 1'b0;
                end else begin
                    out_idx <= out_idx + ADDR_ONE;
                end
            end
            // traceback emits newest bit first; fill from the top so index 0 is oldest
            if (bank_rel) begin
                cap_cnt  <= '0;
                buf_full <= 1'b1;
            end else if (cap_fire) begin
                rev_buf[ADDR_MAX - cap_cnt[AW-1:0]] <= tbu_d_o;
                cap_cnt <= cap_cnt + CAP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_tbu_ctrl.sv
// Bench for tbu_ctrl: random decision vectors, a RAM + traceback-unit model, and a
// scoreboard expecting each decoded bit to be the parity of the matching input vector.
module tb_tbu_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_dec = '0;
    logic          mem_wr_en;
    logic [1:0]    mem_wr_bank;
    logic [AW-1:0] mem_wr_addr;
    logic [7:0]    mem_wr_data;
    logic          mem_rd_en;
    logic [1:0]    mem_rd_bank_0;
    logic [1:0]    mem_rd_bank_1;
    logic [AW-1:0] mem_rd_addr;
    logic          tbu_enable;
    logic          tbu_selection;
    logic          tbu_d_o = 1'b0;
    logic          tbu_wr_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_bit;
    logic          busy;

    always #5 clk = ~clk;

    tbu_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
        .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en),
        .mem_rd_bank_0(mem_rd_bank_0), .mem_rd_bank_1(mem_rd_bank_1), .mem_rd_addr(mem_rd_addr),
        .tbu_enable(tbu_enable), .tbu_selection(tbu_selection),
        .tbu_d_o(tbu_d_o), .tbu_wr_en(tbu_wr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .busy(busy)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_q[$];
    bit   pend[$];
    int   wr_count = 0;
    int   rd_k = 0;
    int   rd_i = 0;
    logic [7:0] ram [4][DEPTH];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_in(input bit v, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_dec    = 8'($urandom);
        out_ready = r;
        #1;
        if (in_valid && in_ready) begin
            check("wr_en", mem_wr_en, 1);
            check("wr_bank", mem_wr_bank, (wr_count / DEPTH) % 4);
            check("wr_addr", mem_wr_addr, wr_count % DEPTH);
            check("wr_data", mem_wr_data, in_dec);
            exp_q.push_back(^in_dec);
            wr_count++;
        end else if (in_valid) begin
            check("wr_blocked", mem_wr_en, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        wr_count = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic write_n(input int n, input bit r);
        int guard = 0;
        while (wr_count < n && guard < 1000) begin
            step_in(1'b1, r);
            guard++;
        end
        check("write_n_done", wr_count, n);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > DEPTH && guard < 3000) begin
            step_in(1'b0, 1'b1);
            guard++;
        end
        check("drain_left", exp_q.size(), DEPTH);
        repeat (5) step_in(1'b0, 1'b1);
        check("busy_after_drain", busy, 0);
        check("out_valid_after_drain", out_valid, 0);
    endtask

    // RAM, traceback-unit and output monitor
    initial begin
        bit         prev_rd_en = 1'b0;
        bit         prev_sel = 1'b0;
        logic [7:0] prev_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                pend.delete();
                rd_k = 0; rd_i = 0;
                prev_rd_en = 1'b0; prev_sel = 1'b0;
                tbu_wr_en = 1'b0; tbu_d_o = 1'b0;
                continue;
            end
            check("tbu_enable_align", tbu_enable, prev_rd_en);
            if (tbu_enable) check("tbu_sel_align", tbu_selection, prev_sel);
            if (tbu_enable && tbu_selection) pend.push_back(^prev_data);
            prev_rd_en = mem_rd_en;
            prev_sel   = 1'b0;
            if (mem_rd_en) begin
                check("rd_addr", mem_rd_addr, DEPTH - 1 - (rd_i % DEPTH));
                check("rd_bank_1", mem_rd_bank_1, rd_k % 4);
                check("rd_bank_0", mem_rd_bank_0, (rd_k + 1) % 4);
                prev_sel  = (rd_i >= DEPTH);
                prev_data = ram[mem_rd_bank_1][mem_rd_addr];
                rd_i++;
                if (rd_i == 2 * DEPTH) begin
                    rd_i = 0;
                    rd_k++;
                end
            end
            if (mem_wr_en) ram[mem_wr_bank][mem_wr_addr] = mem_wr_data;
            if (pend.size() > 0 && ($urandom % 4) != 0) begin
                tbu_wr_en = 1'b1;
                tbu_d_o   = pend.pop_front();
            end else begin
                tbu_wr_en = 1'b0;
                tbu_d_o   = 1'($urandom);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", 1, 0);
                else check("out_bit", out_bit, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // reset values
        #7;
        check("rst_in_ready", in_ready, 1);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_tbu_enable", tbu_enable, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        do_reset();

        // reset in the middle of a decode pass
        write_n(2 * DEPTH, 1'b1);
        guard = 0;
        while (!tbu_selection && guard < 200) begin
            step_in(1'b0, 1'b1);
            guard++;
        end
        check("reached_decode", tbu_selection, 1);
        rst = 1'b0;
        #1;
        check("midrst_tbu_enable", tbu_enable, 0);
        check("midrst_tbu_sel", tbu_selection, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", mem_rd_en, 0);
        exp_q.delete();
        wr_count = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        write_n(2 * DEPTH, 1'b1);
        drain();
        check("blocks_after_midrst", rd_k, 1);

        // random traffic, 11 blocks in, 10 decoded
        do_reset();
        guard = 0;
        while (wr_count < 11 * DEPTH && guard < 5000) begin
            step_in(($urandom % 4) != 0, ($urandom % 4) != 0);
            guard++;
        end
        check("random_writes", wr_count, 11 * DEPTH);
        drain();
        check("random_blocks", rd_k, 10);

        // stalled sink: banks fill, input blocks, single traceback
        do_reset();
        for (int c = 0; c < 200; c++) step_in(1'b1, 1'b0);
        check("stall_accepted", wr_count, 4 * DEPTH);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_blocks", rd_k, 1);
        check("stall_queue", exp_q.size(), 4 * DEPTH);
        write_n(5 * DEPTH, 1'b1);
        drain();
        check("stall_blocks_final", rd_k, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
